// File: rtl/gerenciador_asteroides_n.sv
// gerenciador_asteroides_n
// Multi-asteroid manager for the astro_genius core. Holds N_AST asteroid
// slots, accepts spawn requests, moves every live asteroid one step toward
// the ship at (CENTER,CENTER) on each movement tick, and resolves directional
// shots. It also detects asteroids reaching the ship, owns the life counter
// and flags game over.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   iniciar             start/restart pulse (OCIOSO/FIM -> ATIVO)
//   clear_asteroide     level; frees every slot while ATIVO
//   spawn, spawn_x/y    spawn request and its coordinates
//   tiro, direcao       shot pulse; 00 up, 01 down, 10 right, 11 left
//   colisao             pulse: an asteroid reached the ship
//   acertou / errou     pulse: shot destroyed an asteroid / hit nothing
//   cheio               pulse: spawn dropped because all slots were busy
//   perdeu              high while in FIM
//   vidas               remaining lives
//   ocupados            slot valid bits
//   ast_x / ast_y       packed coordinates, slot i at [i*COORD_W +: COORD_W]
//   db_estado           FSM state code
module gerenciador_asteroides_n #(
    parameter int unsigned N_AST       = 4,
    parameter int unsigned COORD_W     = 4,
    parameter int unsigned CENTER      = 8,
    parameter int unsigned MOVE_PERIOD = 4,
    parameter int unsigned N_VIDAS     = 3,
    parameter int unsigned VIDAS_W     = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       iniciar,
    input  logic                       clear_asteroide,
    input  logic                       spawn,
    input  logic [COORD_W-1:0]         spawn_x,
    input  logic [COORD_W-1:0]         spawn_y,
    input  logic                       tiro,
    input  logic [1:0]                 direcao,
    output logic                       colisao,
    output logic                       acertou,
    output logic                       errou,
    output logic                       cheio,
    output logic                       perdeu,
    output logic [VIDAS_W-1:0]         vidas,
    output logic [N_AST-1:0]           ocupados,
    output logic [N_AST*COORD_W-1:0]   ast_x,
    output logic [N_AST*COORD_W-1:0]   ast_y,
    output logic [1:0]                 db_estado
);

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        ATIVO  = 2'b01,
        FIM    = 2'b10
    } estado_t;

    localparam int unsigned TICK_W = $clog2(MOVE_PERIOD);
    localparam logic [COORD_W-1:0] CEN      = COORD_W'(CENTER);
    localparam logic [TICK_W-1:0]  TICK_MAX = TICK_W'(MOVE_PERIOD - 1);

    estado_t              state_q, state_d;
    logic [VIDAS_W-1:0]   vidas_q, vidas_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [N_AST-1:0]     valid_q, valid_d;
    logic [COORD_W-1:0]   x_q [N_AST];
    logic [COORD_W-1:0]   x_d [N_AST];
    logic [COORD_W-1:0]   y_q [N_AST];
    logic [COORD_W-1:0]   y_d [N_AST];
    logic                 colisao_q, colisao_d;
    logic                 acertou_q, acertou_d;
    logic                 errou_q, errou_d;
    logic                 cheio_q, cheio_d;

    logic                 tick;
    logic                 alinhado;
    logic                 hit_found, free_found, coll;
    logic [N_AST-1:0]     hit_oh, free_oh;
    logic [COORD_W-1:0]   nx, ny;

    assign tick = (tick_q == TICK_MAX);

    always_comb begin
        state_d    = state_q;
        vidas_d    = vidas_q;
        tick_d     = tick_q;
        valid_d    = valid_q;
        x_d        = x_q;
        y_d        = y_q;
        colisao_d  = 1'b0;
        acertou_d  = 1'b0;
        errou_d    = 1'b0;
        cheio_d    = 1'b0;
        alinhado   = 1'b0;
        hit_found  = 1'b0;
        free_found = 1'b0;
        coll       = 1'b0;
        hit_oh     = '0;
        free_oh    = '0;
        nx         = '0;
        ny         = '0;

        // Selection masks are built from start-of-cycle state so that a slot
        // freed this cycle is never reused by a spawn in the same cycle.
        for (int unsigned i = 0; i < N_AST; i++) begin
            case (direcao)
                2'b00:   alinhado = (x_q[i] == CEN) && (y_q[i] > CEN);
                2'b01:   alinhado = (x_q[i] == CEN) && (y_q[i] < CEN);
                2'b10:   alinhado = (y_q[i] == CEN) && (x_q[i] > CEN);
                default: alinhado = (y_q[i] == CEN) && (x_q[i] < CEN);
            endcase
            if (!hit_found && valid_q[i] && alinhado) begin
                hit_found = 1'b1;
                hit_oh[i] = 1'b1;
            end
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_oh[i] = 1'b1;
            end
        end

        case (state_q)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    state_d = ATIVO;
                    vidas_d = VIDAS_W'(N_VIDAS);
                    tick_d  = '0;
                    valid_d = '0;
                    for (int unsigned i = 0; i < N_AST; i++) begin
                        x_d[i] = '0;
                        y_d[i] = '0;
                    end
                end
            end
            ATIVO: begin
                tick_d = tick ? '0 : tick_q + TICK_W'(1);
                if (clear_asteroide) begin
                    valid_d = '0;
                end else begin
                    if (tiro) begin
                        if (hit_found) begin
                            valid_d   = valid_d & ~hit_oh;
                            acertou_d = 1'b1;
                        end else begin
                            errou_d = 1'b1;
                        end
                    end
                    if (tick) begin
                        for (int unsigned i = 0; i < N_AST; i++) begin
                            if (valid_q[i] && !(tiro && hit_oh[i])) begin
                                nx = x_q[i];
                                ny = y_q[i];
                                if (x_q[i] < CEN) nx = x_q[i] + COORD_W'(1);
                                else if (x_q[i] > CEN) nx = x_q[i] - COORD_W'(1);
                                if (y_q[i] < CEN) ny = y_q[i] + COORD_W'(1);
                                else if (y_q[i] > CEN) ny = y_q[i] - COORD_W'(1);
                                x_d[i] = nx;
                                y_d[i] = ny;
                                if (nx == CEN && ny == CEN) begin
                                    valid_d[i] = 1'b0;
                                    coll       = 1'b1;
                                end
                            end
                        end
                    end
                    if (spawn) begin
                        if (free_found) begin
                            valid_d = valid_d | free_oh;
                            for (int unsigned i = 0; i < N_AST; i++) begin
                                if (free_oh[i]) begin
                                    x_d[i] = spawn_x;
                                    y_d[i] = spawn_y;
                                end
                            end
                        end else begin
                            cheio_d = 1'b1;
                        end
                    end
                    // One life per tick no matter how many slots collided.
                    if (coll) begin
                        colisao_d = 1'b1;
                        vidas_d   = (vidas_q == '0) ? '0 : vidas_q - VIDAS_W'(1);
                    end
                end
                if (vidas_d == '0) state_d = FIM;
            end
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= OCIOSO;
            vidas_q   <= '0;
            tick_q    <= '0;
            valid_q   <= '0;
            x_q       <= '{default: '0};
            y_q       <= '{default: '0};
            colisao_q <= 1'b0;
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
            cheio_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            vidas_q   <= vidas_d;
            tick_q    <= tick_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colisao_q <= colisao_d;
            acertou_q <= acertou_d;
            errou_q   <= errou_d;
            cheio_q   <= cheio_d;
        end
    end

    always_comb begin
        ast_x = '0;
        ast_y = '0;
        for (int unsigned i = 0; i < N_AST; i++) begin
            ast_x[i*COORD_W +: COORD_W] = x_q[i];
            ast_y[i*COORD_W +: COORD_W] = y_q[i];
        end
    end

    assign colisao   = colisao_q;
    assign acertou   = acertou_q;
    assign errou     = errou_q;
    assign cheio     = cheio_q;
    assign perdeu    = (state_q == FIM);
    assign vidas     = vidas_q;
    assign ocupados  = valid_q;
    assign db_estado = state_q;

endmodule
